shift_reg_seq: RTL and testbench

Command sequencer for the 6-bit shift/rotate register. It accepts one job over a valid/ready command port: start value, mode, direction, step count and a serial-in bit pattern. It drives the register once per clock, feeding the register's output back to its input, so an N-step job takes N consecutive cycles. It then returns the final value over a valid/ready response port. The shift register itself is external; this block sits between it and the requester.

---
 rtl/shift_reg_seq.sv | 124 ++++++++++++
 tb/tb_shift_reg_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq.sv
// Command sequencer for an external 6-bit shift/rotate register: runs one
// N-step job by feeding the register's output back to its input, then returns the result.
module shift_reg_seq #(
  parameter int MAX_STEPS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [5:0]           cmd_data,
  input  logic                 cmd_mode,
  input  logic                 cmd_direction,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic [MAX_STEPS-1:0] cmd_serial,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [5:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [5:0]           sr_datain,
  output logic                 sr_mode,
  output logic                 sr_direction,
  output logic                 sr_serial_in,
  input  logic [5:0]           sr_dataout
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t               state, state_next;
  logic [CNT_W-1:0]     eff;
  logic                 over;
  logic [CNT_W-1:0]     remain;
  logic [MAX_STEPS-1:0] serial_q;
  logic [5:0]           data_q;
  logic                 mode_q, dir_q, err_q, first_q;

  always_comb begin
    over = (cmd_count > MAX_C);
    eff  = over ? MAX_C : cmd_count;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    sr_datain    = 6'd0;
    sr_mode      = 1'b0;
    sr_direction = 1'b0;
    sr_serial_in = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = (eff == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        // First step loads the start value; later steps recirculate the register output.
        sr_datain    = first_q ? data_q : sr_dataout;
        sr_mode      = mode_q;
        sr_direction = dir_q;
        sr_serial_in = serial_q[0];
        if (remain == ONE_C) state_next = CAPTURE;
      end
      CAPTURE: state_next = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      serial_q <= '0;
      remain   <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          data_q   <= cmd_data;
          mode_q   <= cmd_mode;
          dir_q    <= cmd_direction;
          serial_q <= cmd_serial;
          remain   <= eff;
          err_q    <= over;
          first_q  <= 1'b1;
          if (eff == '0) begin
            rsp_data <= cmd_data;
            rsp_err  <= over;
          end
        end
        SHIFT: begin
          // Serial bits are consumed LSB-first, so bit k lands on step k.
          remain   <= remain - ONE_C;
          serial_q <= serial_q >> 1;
          first_q  <= 1'b0;
        end
        CAPTURE: begin
          rsp_data <= sr_dataout;
          rsp_err  <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: table vectors, hand-written corner sequences and
// random jobs checked against an arithmetic reference model.
module tb_shift_reg_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_mode, cmd_direction;
  logic [5:0]  cmd_data;
  logic [4:0]  cmd_count;
  logic [15:0] cmd_serial;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [5:0]  rsp_data;
  logic [5:0]  sr_datain;
  logic        sr_mode, sr_direction, sr_serial_in;
  logic [5:0]  sr_dataout = 6'd0;

  int pass_cnt = 0;
  int total    = 0;
  logic [5:0] trace [0:63];

  always #5 clk = ~clk;

  shift_reg_seq #(.MAX_STEPS(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_mode(cmd_mode), .cmd_direction(cmd_direction), .cmd_count(cmd_count),
    .cmd_serial(cmd_serial),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .sr_datain(sr_datain), .sr_mode(sr_mode), .sr_direction(sr_direction),
    .sr_serial_in(sr_serial_in), .sr_dataout(sr_dataout)
  );

  // External free-running shift/rotate register with a registered output.
  always @(posedge clk) begin
    case ({sr_mode, sr_direction})
      2'b00: sr_dataout <= {sr_serial_in, sr_datain[5:1]};
      2'b01: sr_dataout <= {sr_datain[4:0], sr_serial_in};
      2'b10: sr_dataout <= {sr_datain[0], sr_datain[5:1]};
      default: sr_dataout <= {sr_datain[4:0], sr_datain[5]};
    endcase
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference: {err, result} from step count, rotation as modular arithmetic, shifts stepwise.
  function automatic logic [6:0] model(input logic [5:0] d, input logic m, input logic dr,
                                       input logic [4:0] c, input logic [15:0] s);
    int n = (c > 16) ? 16 : int'(c);
    int v = int'(d);
    int r;
    if (m) begin
      r = n % 6;
      if (!dr) r = (6 - r) % 6;
      v = ((v << r) | (v >> (6 - r))) & 63;
    end else begin
      for (int i = 0; i < n; i++)
        if (dr) v = ((v << 1) | int'(s[i])) & 63;
        else    v = (v >> 1) | (int'(s[i]) << 5);
    end
    return {c > 16, 6'(v)};
  endfunction

  task automatic run_job(input logic [5:0] d, input logic m, input logic dr,
                         input logic [4:0] c, input logic [15:0] s, input int hold,
                         input logic [5:0] exp_d,
                         output logic [5:0] gd, output logic ge, output int lat);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("cmd_ready_before_job", cmd_ready, 1);
    cmd_data = d; cmd_mode = m; cmd_direction = dr; cmd_count = c; cmd_serial = s;
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      trace[lat] = sr_dataout;
    end while (!rsp_valid && lat < 60);
    gd = rsp_data; ge = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp_d);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drops", rsp_valid, 0);
    check("cmd_ready_returns", cmd_ready, 1);
    check("sr_datain_idle", sr_datain, 0);
  endtask

  typedef struct {
    logic [5:0]  data;
    logic        mode, dir;
    logic [4:0]  count;
    logic [15:0] serial;
    logic [5:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [5:0] gd;
    logic       ge;
    int         lat, eff, seen;
    logic [6:0] mr;

    vecs[0] = '{6'b000001, 1'b1, 1'b1, 5'd3,  16'h0000, 6'b001000, 1'b0};
    vecs[1] = '{6'b101010, 1'b0, 1'b1, 5'd4,  16'h000B, 6'b101101, 1'b0};
    vecs[2] = '{6'b111111, 1'b0, 1'b0, 5'd6,  16'h0000, 6'b000000, 1'b0};
    vecs[3] = '{6'b100110, 1'b1, 1'b0, 5'd6,  16'h0000, 6'b100110, 1'b0};
    vecs[4] = '{6'b000001, 1'b1, 1'b0, 5'd31, 16'h0000, 6'b000100, 1'b1};
    vecs[5] = '{6'b010011, 1'b0, 1'b1, 5'd0,  16'hFFFF, 6'b010011, 1'b0};
    vecs[6] = '{6'b000000, 1'b0, 1'b0, 5'd16, 16'hFFFF, 6'b111111, 1'b0};
    vecs[7] = '{6'b000000, 1'b0, 1'b1, 5'd17, 16'hFC00, 6'b111111, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_data = '0; cmd_mode = 1'b0; cmd_direction = 1'b0; cmd_count = '0; cmd_serial = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_err", rsp_err, 0);

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].data, vecs[i].mode, vecs[i].dir, vecs[i].count, vecs[i].serial,
              0, vecs[i].exp_data, gd, ge, lat);
      eff = (vecs[i].count > 16) ? 16 : int'(vecs[i].count);
      check($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
      check($sformatf("vec%0d_latency", i), lat, (eff == 0) ? 1 : eff + 2);
      if (i == 1) begin
        check("step0", trace[2], 6'b010101);
        check("step1", trace[3], 6'b101011);
        check("step2", trace[4], 6'b010110);
        check("step3", trace[5], 6'b101101);
      end
    end

    // Backpressure: response must sit stable for 10 cycles.
    run_job(6'b000011, 1'b1, 1'b1, 5'd2, 16'h0, 10, 6'b001100, gd, ge, lat);
    check("bp_data", gd, 6'b001100);

    // Reset in the middle of a SHIFT phase discards the job.
    @(negedge clk);
    cmd_data = 6'b110011; cmd_mode = 1'b0; cmd_direction = 1'b1; cmd_count = 5'd10;
    cmd_serial = 16'h0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_rsp_data", rsp_data, 0);
    seen = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    check("no_rsp_after_reset", seen, 0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  d  = 6'($urandom);
      logic        m  = 1'($urandom);
      logic        dr = 1'($urandom);
      logic [4:0]  c  = 5'($urandom_range(0, 31));
      logic [15:0] s  = 16'($urandom);
      int          h  = $urandom_range(0, 3);
      mr  = model(d, m, dr, c, s);
      eff = (c > 16) ? 16 : int'(c);
      run_job(d, m, dr, c, s, h, mr[5:0], gd, ge, lat);
      check($sformatf("rand%0d_data", i), gd, mr[5:0]);
      check($sformatf("rand%0d_err", i), ge, mr[6]);
      check($sformatf("rand%0d_latency", i), lat, (eff == 0) ? 1 : eff + 2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
